serial_add_ctrl: RTL and testbench

//   Bit-serial multi-bit adder controller. Time-shares one single-bit full adder
//   (fa_behavioral, ports a/b/ci/s/co) across WIDTH cycles to add two WIDTH-bit operands.

---
 rtl/serial_add_ctrl.sv | 93 +++++++++
 tb/tb_serial_add_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder sharing one full adder over WIDTH cycles.
// Define SERIAL_ADD_SUB_EN to add the sub port (a - b via inverted B and carry-in of 1).
module fa_behavioral (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci_in,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co_out
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic [CW-1:0]    count;
    logic             carry, fa_s, fa_co, b_in, ci_init;
`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is folded into capture: B is stored inverted and carry starts at 1.
    assign b_in    = 1'b0;
    assign ci_init = sub | ci_in;
`else
    assign b_in    = 1'b0;
    assign ci_init = ci_in;
`endif
    fa_behavioral u_fa (.a(a_sr[0]), .b(b_sr[0]), .ci(carry), .s(fa_s), .co(fa_co));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            co_out <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= SHIFT;
                    busy  <= 1'b1;
                    a_sr  <= a;
`ifdef SERIAL_ADD_SUB_EN
                    b_sr  <= sub ? ~b : b;
`else
                    b_sr  <= b ^ {WIDTH{b_in}};
`endif
                    carry <= ci_init;
                    count <= '0;
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {fa_s, res_sr[WIDTH-1:1]};
                    carry  <= fa_co;
                    count  <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        sum    <= {fa_s, res_sr[WIDTH-1:1]};
                        co_out <= fa_co;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed self-checking bench for serial_add_ctrl (WIDTH=8).
module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       ci_in = 1'b0;
    logic       busy, done, co_out;
    logic [7:0] sum;
    logic [7:0] last_sum = '0;
    logic       last_co = 1'b0;
    int         tests = 0, fails = 0;
`ifdef SERIAL_ADD_SUB_EN
    logic       sub = 1'b0;
`endif

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .ci_in(ci_in),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .co_out(co_out)
    );

    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic xci,
                          input logic xsub, input logic [7:0] es, input logic ec, input string nm);
        @(negedge clk);
        a = xa; b = xb; ci_in = xci; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        sub = xsub;
`else
        if (xsub) $display("[TB] note: sub requested without SERIAL_ADD_SUB_EN");
`endif
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (busy !== 1'b1 || done !== 1'b0 || sum !== last_sum || co_out !== last_co) begin
                fails++;
                $display("FAIL %s busy cycle %0d: busy=%b done=%b sum=%h co=%b, required busy=1 done=0 sum=%h co=%b",
                         nm, i, busy, done, sum, co_out, last_sum, last_co);
            end
            @(posedge clk); #1;
        end
        tests++;
        if (busy !== 1'b0 || done !== 1'b1 || sum !== es || co_out !== ec) begin
            fails++;
            $display("FAIL %s result: busy=%b done=%b sum=%h co=%b, required busy=0 done=1 sum=%h co=%b",
                     nm, busy, done, sum, co_out, es, ec);
        end
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== es || co_out !== ec) begin
            fails++;
            $display("FAIL %s after done: busy=%b done=%b sum=%h co=%b, required busy=0 done=0 sum=%h co=%b",
                     nm, busy, done, sum, co_out, es, ec);
        end
        last_sum = es;
        last_co  = ec;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || co_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_held: busy=%b done=%b sum=%h co=%b, required all zero", busy, done, sum, co_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || co_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b done=%b sum=%h co=%b, required all zero", busy, done, sum, co_out);
        end
    endtask

    task automatic test_add();
        run_op(8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, "add_5a_33");
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "add_ff_01");
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, "add_ff_ff_ci");
        run_op(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, "add_ci_only");
        run_op(8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0, "add_a5_5a");
    endtask

    task automatic test_ignore_start();
        int pulses = 0;
        @(negedge clk);
        a = 8'h5A; b = 8'h33; ci_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 3) begin a = 8'h01; b = 8'h01; start = 1'b1; end
            if (i == 4) start = 1'b0;
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        tests++;
        if (pulses != 1 || sum !== 8'h8D || co_out !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL ignore_start: pulses=%0d sum=%h co=%b busy=%b, required pulses=1 sum=8d co=0 busy=0",
                     pulses, sum, co_out, busy);
        end
        last_sum = 8'h8D;
        last_co  = 1'b0;
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        @(negedge clk);
        a = 8'h5A; b = 8'h33; ci_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || co_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: busy=%b done=%b sum=%h co=%b, required all zero", busy, done, sum, co_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        tests++;
        if (pulses != 0 || sum !== 8'h00) begin
            fails++;
            $display("FAIL reset_mid_quiet: activity_cycles=%0d sum=%h, required 0 and 00", pulses, sum);
        end
        last_sum = 8'h00;
        last_co  = 1'b0;
        run_op(8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, "after_reset_mid");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        a = 8'h01; b = 8'h02; ci_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 8'h10; b = 8'h20;
        for (int e = 1; e <= 19; e++) begin
            @(posedge clk); #1;
            if (e == 8) begin
                tests++;
                if (done !== 1'b1 || sum !== 8'h03 || co_out !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_first: done=%b sum=%h co=%b, required done=1 sum=03 co=0", done, sum, co_out);
                end
            end
            if (e == 9) begin
                tests++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_idle_edge: done=%b busy=%b, required 0 0", done, busy);
                end
            end
            if (e == 10) begin
                tests++;
                if (busy !== 1'b1 || sum !== 8'h03) begin
                    fails++;
                    $display("FAIL b2b_reaccept: busy=%b sum=%h, required busy=1 sum=03", busy, sum);
                end
                start = 1'b0;
                a = 8'hFF;
            end
            if (e == 18) begin
                tests++;
                if (done !== 1'b1 || sum !== 8'h30 || co_out !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_second: done=%b sum=%h co=%b, required done=1 sum=30 co=0", done, sum, co_out);
                end
            end
            if (e == 19) begin
                tests++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_end: done=%b busy=%b, required 0 0", done, busy);
                end
            end
        end
        last_sum = 8'h30;
        last_co  = 1'b0;
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, "sub_10_01");
        run_op(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, "sub_00_01");
        run_op(8'h10, 8'h01, 1'b1, 1'b0, 8'h12, 1'b0, "sub0_add");
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
